// File: rtl/ttt_move_sched.sv
// Turn scheduler and arbiter for the tic-tac-toe board write port.
// Alternates human and AI moves, validates coordinates, retries failed AI moves and detects game end.
module ttt_move_sched #(
    parameter logic [1:0] FIRST_PLAYER = 2'b01,
    parameter int         AI_TIMEOUT   = 15,
    parameter int         CELLS        = 9
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       new_game,
    input  logic       hum_req,
    input  logic [1:0] hum_xoro,
    input  logic [1:0] hum_row,
    input  logic [1:0] hum_col,
    output logic       hum_ack,
    output logic       hum_err,
    input  logic       ai_en,
    output logic       ai_start,
    input  logic       ai_valid,
    input  logic [1:0] ai_row,
    input  logic [1:0] ai_col,
    output logic       brd_we,
    output logic [1:0] brd_xoro,
    output logic [1:0] brd_row,
    output logic [1:0] brd_col,
    input  logic       brd_done,
    input  logic       brd_err,
    input  logic [1:0] win,
    output logic [1:0] turn,
    output logic [3:0] move_cnt,
    output logic       game_over,
    output logic       err
);

    localparam int TW = $clog2(AI_TIMEOUT + 1);

    typedef enum logic [2:0] {
        WAIT_MOVE, AI_REQ, AI_WAIT, WRITE, WAIT_BRD, CHECK, OVER
    } state_t;

    state_t        state, state_next;
    logic [TW-1:0] timer;
    logic          src_ai;
    logic          hum_ack_d, hum_err_d, err_d;
    logic          latch_hum, latch_ai, cnt_inc, turn_flip;

    assign brd_we    = (state == WRITE);
    assign ai_start  = (state == AI_REQ);
    assign game_over = (state == OVER);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= WAIT_MOVE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        hum_ack_d  = 1'b0;
        hum_err_d  = 1'b0;
        err_d      = 1'b0;
        latch_hum  = 1'b0;
        latch_ai   = 1'b0;
        cnt_inc    = 1'b0;
        turn_flip  = 1'b0;
        case (state)
            WAIT_MOVE: begin
                if (ai_en && turn == 2'b10) begin
                    state_next = AI_REQ;
                    hum_err_d  = hum_req;
                    err_d      = hum_req;
                end else if (hum_req) begin
                    if (hum_xoro == turn && hum_row != 2'd3 && hum_col != 2'd3) begin
                        latch_hum  = 1'b1;
                        state_next = WRITE;
                    end else begin
                        hum_err_d = 1'b1;
                        err_d     = 1'b1;
                    end
                end
            end
            AI_REQ: begin
                state_next = AI_WAIT;
                hum_err_d  = hum_req;
                err_d      = hum_req;
            end
            AI_WAIT: begin
                hum_err_d = hum_req;
                err_d     = hum_req;
                if (!ai_en) begin
                    state_next = WAIT_MOVE;
                end else if (ai_valid && ai_row != 2'd3 && ai_col != 2'd3) begin
                    latch_ai   = 1'b1;
                    state_next = WRITE;
                end else if (ai_valid || timer == TW'(AI_TIMEOUT - 1)) begin
                    err_d      = 1'b1;
                    state_next = AI_REQ;
                end
            end
            WRITE: state_next = WAIT_BRD;
            WAIT_BRD: begin
                // ai_en is deliberately not looked at here; an AI retry re-checks it in AI_WAIT
                if (brd_done) begin
                    if (brd_err) begin
                        err_d      = 1'b1;
                        hum_err_d  = !src_ai;
                        state_next = src_ai ? AI_REQ : WAIT_MOVE;
                    end else begin
                        cnt_inc    = 1'b1;
                        hum_ack_d  = !src_ai;
                        state_next = CHECK;
                    end
                end
            end
            CHECK: begin
                if (win != 2'b00 || move_cnt == 4'(CELLS)) begin
                    state_next = OVER;
                end else begin
                    turn_flip  = 1'b1;
                    state_next = WAIT_MOVE;
                end
            end
            OVER: begin
                hum_err_d = hum_req;
                err_d     = hum_req;
            end
            default: state_next = WAIT_MOVE;
        endcase
        if (new_game) state_next = WAIT_MOVE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            turn     <= FIRST_PLAYER;
            move_cnt <= '0;
            timer    <= '0;
            src_ai   <= 1'b0;
            brd_xoro <= '0;
            brd_row  <= '0;
            brd_col  <= '0;
            hum_ack  <= 1'b0;
            hum_err  <= 1'b0;
            err      <= 1'b0;
        end else if (new_game) begin
            turn     <= FIRST_PLAYER;
            move_cnt <= '0;
            timer    <= '0;
            src_ai   <= 1'b0;
            brd_xoro <= '0;
            brd_row  <= '0;
            brd_col  <= '0;
            hum_ack  <= 1'b0;
            hum_err  <= 1'b0;
            err      <= 1'b0;
        end else begin
            hum_ack <= hum_ack_d;
            hum_err <= hum_err_d;
            err     <= err_d;
            if (state == AI_REQ)       timer <= '0;
            else if (state == AI_WAIT) timer <= timer + 1'b1;
            // Latched move stays on brd_* until the next move is accepted
            if (latch_hum) begin
                brd_xoro <= hum_xoro;
                brd_row  <= hum_row;
                brd_col  <= hum_col;
                src_ai   <= 1'b0;
            end else if (latch_ai) begin
                brd_xoro <= 2'b10;
                brd_row  <= ai_row;
                brd_col  <= ai_col;
                src_ai   <= 1'b1;
            end
            if (cnt_inc && move_cnt != 4'(CELLS)) move_cnt <= move_cnt + 1'b1;
            if (turn_flip) turn <= ~turn;
        end
    end

endmodule
